vga_timing_gen: RTL and testbench

//  Raster timing source for the VGA path, directly upstream of the scene renderers.

---
 rtl/vga_timing_pkg.sv | 28 ++
 rtl/clk_enable_div.sv | 29 ++
 rtl/vga_timing_gen.sv | 95 +++++++++
 tb/tb_vga_timing_gen.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - default 640x480@60 timing constants and window helper
package vga_timing_pkg;

  localparam int DEF_CLK_DIV   = 2;
  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;
  localparam int DEF_SYNC_POL  = 0;

  localparam int DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  localparam int DEF_H_SYNC_START = DEF_H_VISIBLE + DEF_H_FRONT;
  localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC - 1;
  localparam int DEF_V_SYNC_START = DEF_V_VISIBLE + DEF_V_FRONT;
  localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC - 1;

  // Inclusive window test used for both sync pulses.
  function automatic logic in_window(input int val, input int lo, input int hi);
    return (val >= lo) && (val <= hi);
  endfunction

endpackage

// File: rtl/clk_enable_div.sv
// rtl/clk_enable_div.sv - divides clk into a one-in-CLK_DIV pixel enable
module clk_enable_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick_next,
  output logic pix_tick
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div;

  // tick_next lets the raster counters advance on the same edge pix_tick rises.
  assign tick_next = (div == DIV_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div      <= '0;
      pix_tick <= 1'b0;
    end else begin
      div      <= tick_next ? '0 : div + 1'b1;
      pix_tick <= tick_next;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - 640x480@60 raster counters, syncs, display window and strobes
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter int SYNC_POL  = DEF_SYNC_POL
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        pix_tick,
  output logic [9:0]  CounterX,
  output logic [8:0]  CounterY,
  output logic [9:0]  vcount,
  output logic        display_on,
  output logic        vga_h_sync,
  output logic        vga_v_sync,
  output logic        line_start,
  output logic        frame_start,
  output logic [24:0] anim_cnt
);

  localparam int H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic       SYNC_ACT = 1'(SYNC_POL);

  logic       tick_next;
  logic [9:0] hcount;
  logic [9:0] h_nxt;
  logic [9:0] v_nxt;

  clk_enable_div #(
    .CLK_DIV (CLK_DIV)
  ) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick_next (tick_next),
    .pix_tick  (pix_tick)
  );

  always_comb begin
    h_nxt = hcount;
    v_nxt = vcount;
    if (tick_next) begin
      if (hcount == H_LAST) begin
        h_nxt = '0;
        v_nxt = (vcount == V_LAST) ? '0 : vcount + 10'd1;
      end else begin
        h_nxt = hcount + 10'd1;
      end
    end
  end

  // Every decoded output is registered from the next-state counters so it
  // lands in the same cycle as the counter value it describes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hcount      <= H_LAST;
      vcount      <= V_LAST;
      display_on  <= 1'b0;
      vga_h_sync  <= ~SYNC_ACT;
      vga_v_sync  <= ~SYNC_ACT;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      anim_cnt    <= '0;
    end else begin
      hcount      <= h_nxt;
      vcount      <= v_nxt;
      display_on  <= (int'(h_nxt) < H_VISIBLE) && (int'(v_nxt) < V_VISIBLE);
      vga_h_sync  <= in_window(int'(h_nxt), H_SYNC_START, H_SYNC_END) ? SYNC_ACT : ~SYNC_ACT;
      vga_v_sync  <= in_window(int'(v_nxt), V_SYNC_START, V_SYNC_END) ? SYNC_ACT : ~SYNC_ACT;
      line_start  <= tick_next && (h_nxt == '0);
      frame_start <= tick_next && (h_nxt == '0) && (v_nxt == '0);
      anim_cnt    <= anim_cnt + 25'd1;
    end
  end

  assign CounterX = hcount;
  assign CounterY = vcount[8:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - randomized-reset raster check against a pixel-index reference model
module tb_vga_timing_gen;

  typedef struct {
    int cd, hv, hf, hs, hb, vv, vf, vs, vb, pol;
  } cfg_t;

  typedef struct packed {
    logic        pt;
    logic [9:0]  h;
    logic [9:0]  v;
    logic        de;
    logic        hsy;
    logic        vsy;
    logic        ls;
    logic        fs;
    logic [24:0] anim;
  } exp_t;

  localparam cfg_t CFG_A = '{cd: 2, hv: 20, hf: 2, hs: 3, hb: 3, vv: 6, vf: 1, vs: 2, vb: 2, pol: 0};
  localparam cfg_t CFG_B = '{cd: 1, hv: 12, hf: 2, hs: 4, hb: 3, vv: 5, vf: 2, vs: 1, vb: 3, pol: 1};
  localparam cfg_t CFG_C = '{cd: 2, hv: 640, hf: 16, hs: 96, hb: 48, vv: 480, vf: 10, vs: 2, vb: 33, pol: 0};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   k = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  logic        a_pt, a_de, a_hs, a_vs, a_ls, a_fs;
  logic [9:0]  a_cx, a_vc;
  logic [8:0]  a_cy;
  logic [24:0] a_an;
  logic        b_pt, b_de, b_hs, b_vs, b_ls, b_fs;
  logic [9:0]  b_cx, b_vc;
  logic [8:0]  b_cy;
  logic [24:0] b_an;
  logic        c_pt, c_de, c_hs, c_vs, c_ls, c_fs;
  logic [9:0]  c_cx, c_vc;
  logic [8:0]  c_cy;
  logic [24:0] c_an;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .CLK_DIV(2), .H_VISIBLE(20), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2), .SYNC_POL(0)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .pix_tick(a_pt), .CounterX(a_cx), .CounterY(a_cy),
    .vcount(a_vc), .display_on(a_de), .vga_h_sync(a_hs), .vga_v_sync(a_vs),
    .line_start(a_ls), .frame_start(a_fs), .anim_cnt(a_an)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_VISIBLE(12), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
    .V_VISIBLE(5), .V_FRONT(2), .V_SYNC(1), .V_BACK(3), .SYNC_POL(1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .pix_tick(b_pt), .CounterX(b_cx), .CounterY(b_cy),
    .vcount(b_vc), .display_on(b_de), .vga_h_sync(b_hs), .vga_v_sync(b_vs),
    .line_start(b_ls), .frame_start(b_fs), .anim_cnt(b_an)
  );

  vga_timing_gen dut_c (
    .clk(clk), .rst_n(rst_n), .pix_tick(c_pt), .CounterX(c_cx), .CounterY(c_cy),
    .vcount(c_vc), .display_on(c_de), .vga_h_sync(c_hs), .vga_v_sync(c_vs),
    .line_start(c_ls), .frame_start(c_fs), .anim_cnt(c_an)
  );

  // k = clock edges since reset was last sampled; pixel t lands on edge t*cd.
  function automatic exp_t model(input int kk, input cfg_t c);
    exp_t e;
    int ht, vt, t, p;
    logic hact, vact;
    ht = c.hv + c.hf + c.hs + c.hb;
    vt = c.vv + c.vf + c.vs + c.vb;
    t  = kk / c.cd;
    e.pt = (kk > 0) && (kk % c.cd == 0);
    if (t == 0) begin
      e.h = 10'(ht - 1);
      e.v = 10'(vt - 1);
    end else begin
      p   = (t - 1) % (ht * vt);
      e.h = 10'(p % ht);
      e.v = 10'(p / ht);
    end
    e.de  = (kk > 0) && (int'(e.h) < c.hv) && (int'(e.v) < c.vv);
    hact  = (int'(e.h) >= c.hv + c.hf) && (int'(e.h) < c.hv + c.hf + c.hs);
    vact  = (int'(e.v) >= c.vv + c.vf) && (int'(e.v) < c.vv + c.vf + c.vs);
    e.hsy = hact ? 1'(c.pol) : ~1'(c.pol);
    e.vsy = vact ? 1'(c.pol) : ~1'(c.pol);
    e.ls  = e.pt && (e.h == 10'd0);
    e.fs  = e.pt && (e.h == 10'd0) && (e.v == 10'd0);
    e.anim = 25'(kk);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [24:0] obs, input logic [24:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s k=%0d observed=%0d expected=%0d", tag, k, obs, exp);
    end
  endtask

  task automatic chk_inst(input string nm, input cfg_t c,
                          input logic pt, input logic [9:0] cx, input logic [8:0] cy,
                          input logic [9:0] vc, input logic de, input logic hs, input logic vs,
                          input logic ls, input logic fs, input logic [24:0] an);
    exp_t e;
    e = model(k, c);
    chk({nm, ".pix_tick"},    25'(pt), 25'(e.pt));
    chk({nm, ".CounterX"},    25'(cx), 25'(e.h));
    chk({nm, ".vcount"},      25'(vc), 25'(e.v));
    chk({nm, ".CounterY"},    25'(cy), 25'(e.v[8:0]));
    chk({nm, ".display_on"},  25'(de), 25'(e.de));
    chk({nm, ".vga_h_sync"},  25'(hs), 25'(e.hsy));
    chk({nm, ".vga_v_sync"},  25'(vs), 25'(e.vsy));
    chk({nm, ".line_start"},  25'(ls), 25'(e.ls));
    chk({nm, ".frame_start"}, 25'(fs), 25'(e.fs));
    chk({nm, ".anim_cnt"},    an, e.anim);
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (!rst_n) k = 0;
      else        k = k + 1;
      @(negedge clk);
      chk_inst("a", CFG_A, a_pt, a_cx, a_cy, a_vc, a_de, a_hs, a_vs, a_ls, a_fs, a_an);
      chk_inst("b", CFG_B, b_pt, b_cx, b_cy, b_vc, b_de, b_hs, b_vs, b_ls, b_fs, b_an);
      chk_inst("c", CFG_C, c_pt, c_cx, c_cy, c_vc, c_de, c_hs, c_vs, c_ls, c_fs, c_an);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(700);
    rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(250);
    for (int r = 0; r < 6; r++) begin
      step(int'($urandom_range(40, 400)));
      rst_n = 1'b0;
      step(int'($urandom_range(1, 4)));
      rst_n = 1'b1;
    end
    step(int'($urandom_range(0, 30)));
    rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(3400);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
